row_clear_engine: RTL



---
 rtl/tetris_pkg.sv | 24 ++
 rtl/row_clear_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, cell addressing and the row-clear state encoding.
// Also used by the collision, add_to_ram and draw_ram blocks.
package tetris_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int COLOUR_W = 6;
    localparam int ADDR_W   = 8;

    localparam logic [COLOUR_W-1:0] EMPTY_CELL = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COPY,
        S_FILL,
        S_DONE
    } rc_state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input int row, input int col);
        return ADDR_W'(row * BOARD_W + col);
    endfunction

endpackage

// File: rtl/row_clear_engine.sv
// Line-clear sequencer: finds full rows, compacts the rest downward, zero-fills
// the top rows, then reports the clear count. Owns the board RAM port while busy.
module row_clear_engine #(
    parameter int BOARD_W  = tetris_pkg::BOARD_W,
    parameter int BOARD_H  = tetris_pkg::BOARD_H,
    parameter int COLOUR_W = tetris_pkg::COLOUR_W,
    parameter int ADDR_W   = tetris_pkg::ADDR_W,
    parameter int CNT_W    = $clog2(BOARD_H + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_lines_cleared,
    output logic                  o_redraw_req,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [COLOUR_W-1:0]   o_ram_wdata,
    output logic                  o_ram_wren,
    input  logic [COLOUR_W-1:0]   i_ram_rdata,
    output tetris_pkg::rc_state_t o_dbg_state
);
    import tetris_pkg::*;

    // Handshake: i_start is a one-cycle request with no ready; it is only
    // honoured in IDLE, and o_busy rises the cycle after it is taken.

    // Pointers carry one extra bit so stepping past row 0 sets the MSB.
    localparam int               RW      = $clog2(BOARD_H) + 1;
    localparam int               COL_W   = $clog2(BOARD_W + 1);
    localparam logic [RW-1:0]    ROW_TOP = RW'(BOARD_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] row, input int col);
        return ADDR_W'(int'(row) * BOARD_W + col);
    endfunction

    rc_state_t         r_state;
    logic [RW-1:0]     r_src;
    logic [RW-1:0]     r_dst;
    logic [CNT_W-1:0]  r_cnt;
    logic [COL_W-1:0]  r_col;
    logic              r_full;
    logic              r_copy_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_redraw;
    logic [CNT_W-1:0]  r_lines;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wren;

    logic              w_nz;
    logic              w_row_full;
    logic              w_last_col;
    logic              w_decide;
    logic              w_to_copy;
    logic              w_advance;
    logic [RW-1:0]     w_src_dec;
    logic [RW-1:0]     w_dst_dec;
    logic [RW-1:0]     w_adv_dst;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] w_fill_last;
    rc_state_t         w_adv_state;
    logic [ADDR_W-1:0] w_adv_addr;

    assign w_nz        = |i_ram_rdata;
    assign w_row_full  = r_full & w_nz;
    assign w_last_col  = (r_col == COL_W'(BOARD_W - 1));
    assign w_decide    = (r_state == S_CHECK) && (r_col == COL_W'(BOARD_W));
    assign w_to_copy   = w_decide && !w_row_full && (r_src != r_dst);
    assign w_advance   = (w_decide && !w_to_copy) ||
                         ((r_state == S_COPY) && r_copy_wr && w_last_col);
    assign w_src_dec   = r_src - 1'b1;
    assign w_dst_dec   = r_dst - 1'b1;
    assign w_adv_dst   = (w_decide && w_row_full) ? r_dst : w_dst_dec;
    assign w_cnt_next  = (w_decide && w_row_full && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
    assign w_fill_last = addr_of(r_dst, BOARD_W - 1);

    // After finishing a row: next row, or fill the top, or finish if nothing cleared.
    always_comb begin
        w_adv_state = S_CHECK;
        w_adv_addr  = addr_of(w_src_dec, 0);
        if (w_src_dec[RW-1]) begin
            w_adv_addr  = '0;
            w_adv_state = w_adv_dst[RW-1] ? S_DONE : S_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_src     <= ROW_TOP;
            r_dst     <= ROW_TOP;
            r_cnt     <= '0;
            r_col     <= '0;
            r_full    <= 1'b1;
            r_copy_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_redraw  <= 1'b0;
            r_lines   <= '0;
            r_addr    <= '0;
            r_wren    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                        r_src   <= ROW_TOP;
                        r_dst   <= ROW_TOP;
                        r_cnt   <= '0;
                        r_col   <= '0;
                        r_full  <= 1'b1;
                        r_addr  <= addr_of(ROW_TOP, 0);
                    end
                end
                S_CHECK: begin
                    if (!w_decide) begin
                        // Read data lags the address by one cycle, so col 0 data lands when r_col==1.
                        if (r_col != '0) r_full <= r_full & w_nz;
                        if (!w_last_col) r_addr <= r_addr + 1'b1;
                        r_col <= r_col + 1'b1;
                    end else if (w_to_copy) begin
                        r_state   <= S_COPY;
                        r_col     <= '0;
                        r_copy_wr <= 1'b0;
                        r_addr    <= addr_of(r_src, 0);
                    end
                end
                S_COPY: begin
                    if (!r_copy_wr) begin
                        r_copy_wr <= 1'b1;
                        r_wren    <= 1'b1;
                        r_addr    <= addr_of(r_dst, int'(r_col));
                    end else begin
                        r_copy_wr <= 1'b0;
                        r_wren    <= 1'b0;
                        if (!w_last_col) begin
                            r_col  <= r_col + 1'b1;
                            r_addr <= addr_of(r_src, int'(r_col) + 1);
                        end
                    end
                end
                S_FILL: begin
                    if (r_addr == w_fill_last) begin
                        r_state  <= S_DONE;
                        r_wren   <= 1'b0;
                        r_done   <= 1'b1;
                        r_lines  <= r_cnt;
                        r_redraw <= (r_cnt != '0);
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_redraw <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                r_state  <= w_adv_state;
                r_src    <= w_src_dec;
                r_dst    <= w_adv_dst;
                r_cnt    <= w_cnt_next;
                r_col    <= '0;
                r_full   <= 1'b1;
                r_addr   <= w_adv_addr;
                r_wren   <= (w_adv_state == S_FILL);
                r_done   <= (w_adv_state == S_DONE);
                r_redraw <= (w_adv_state == S_DONE) && (w_cnt_next != '0);
                if (w_adv_state == S_DONE) r_lines <= w_cnt_next;
            end
        end
    end

    // Copy data is forwarded straight from the RAM read that completes in the write cycle.
    assign o_ram_wdata     = r_copy_wr ? i_ram_rdata : {COLOUR_W{1'b0}};
    assign o_ram_addr      = r_addr;
    assign o_ram_wren      = r_wren;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_redraw_req    = r_redraw;
    assign o_lines_cleared = r_lines;
    assign o_dbg_state     = r_state;

endmodule
